// File: rtl/inv_scan_4x4.sv
// Inverse-scan buffer: places 16 scan-order coefficients at raster positions, ping-pong banked.
// Optional early completion on in_last is enabled by defining LAST_ZERO_FILL_EN.
module inv_scan_4x4 #(
  parameter int COEF_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           scan_type,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [COEF_W-1:0]    in_coef,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [16*COEF_W-1:0] out_block,
  output logic [1:0]           out_scan_type
);

  logic [COEF_W-1:0] bank [2][16];
  logic [15:0]       mask [2];
  logic [1:0]        btype [2];
  logic [1:0]        full;
  logic              wr_sel;
  logic              rd_sel;
  logic [3:0]        cnt;

  logic              accept;
  logic              complete;
  logic              drain;
  logic              last_hit;
  logic [1:0]        cur_type;
  logic [3:0]        pos;

  // Diag walks the four 2x2 quads in raster order, so its map is a bit shuffle of k.
  function automatic logic [3:0] raster_pos(input logic [1:0] t, input logic [3:0] k);
    logic [3:0] p;
    p = {k[3], k[1], k[2], k[0]};
    case (t)
      2'd1:    p = k;
      2'd2:    p = {k[1:0], k[3:2]};
      default: p = {k[3], k[1], k[2], k[0]};
    endcase
    return p;
  endfunction

`ifdef LAST_ZERO_FILL_EN
  assign last_hit = in_last;
`else
  logic unused_last;
  assign unused_last = in_last;
  assign last_hit    = 1'b0;
`endif

  assign in_ready      = rst_n && !full[wr_sel];
  assign accept        = in_valid && in_ready;
  assign cur_type      = (cnt == 4'd0) ? scan_type : btype[wr_sel];
  assign pos           = raster_pos(cur_type, cnt);
  assign complete      = accept && ((cnt == 4'd15) || last_hit);
  assign out_valid     = full[rd_sel];
  assign drain         = out_valid && out_ready;
  assign out_scan_type = btype[rd_sel];

  // Fill and drain never touch the same bank in one cycle, so both may fire together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      wr_sel   <= 1'b0;
      rd_sel   <= 1'b0;
      full     <= '0;
      mask[0]  <= '0;
      mask[1]  <= '0;
      btype[0] <= '0;
      btype[1] <= '0;
    end else begin
      if (accept) begin
        mask[wr_sel][pos] <= 1'b1;
        if (cnt == 4'd0)
          btype[wr_sel] <= scan_type;
        if (complete) begin
          full[wr_sel] <= 1'b1;
          wr_sel       <= ~wr_sel;
          cnt          <= '0;
        end else begin
          cnt <= cnt + 4'd1;
        end
      end
      if (drain) begin
        full[rd_sel] <= 1'b0;
        mask[rd_sel] <= '0;
        rd_sel       <= ~rd_sel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept)
      bank[wr_sel][pos] <= in_coef;
  end

  // The mask hides stale bank data, which also keeps out_block at zero after reset.
  always_comb begin
    out_block = '0;
    for (int r = 0; r < 16; r++) begin
      if (mask[rd_sel][r])
        out_block[r*COEF_W +: COEF_W] = bank[rd_sel][r];
    end
  end

endmodule

// File: tb/tb_inv_scan_4x4.sv
// Scoreboard bench for inv_scan_4x4; expected raster blocks come from table-driven scan maps.
module tb_inv_scan_4x4;

  localparam int W  = 16;
  localparam int BW = 16 * W;
  localparam int DIAG_TAB [16] = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};
  localparam int VER_TAB  [16] = '{0, 4, 8, 12, 1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15};

  typedef struct {
    logic [BW-1:0] blk;
    logic [1:0]    typ;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    scan_type;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_coef;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] out_block;
  logic [1:0]    out_scan_type;

  int            checks = 0;
  int            failures = 0;
  int            acc_cnt = 0;
  exp_t          sb [$];
  logic signed [W-1:0] cv [16];

  inv_scan_4x4 #(.COEF_W(W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .scan_type     (scan_type),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_coef       (in_coef),
    .in_last       (in_last),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_block     (out_block),
    .out_scan_type (out_scan_type)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && in_valid && in_ready)
      acc_cnt <= acc_cnt + 1;
  end

  function automatic logic [BW-1:0] model(input logic [1:0] t, input int n);
    logic [BW-1:0] b;
    int p;
    b = '0;
    for (int k = 0; k < n; k++) begin
      p = (t == 2'd1) ? k : (t == 2'd2) ? VER_TAB[k] : DIAG_TAB[k];
      b[p*W +: W] = cv[k];
    end
    return b;
  endfunction

  function automatic logic [W-1:0] elem(input int r);
    return out_block[r*W +: W];
  endfunction

  // Drives beats start..n-1 back to back; the expected block is queued once the beats are in.
  task automatic send_block(input logic [1:0] t0, input logic [1:0] t1, input int n,
                            input int last_at, input int start, input bit push);
    exp_t e;
    int w;
    for (int k = start; k < n; k++) begin
      in_valid  = 1'b1;
      in_coef   = cv[k];
      scan_type = (k == 0) ? t0 : t1;
      in_last   = (k == last_at);
      w = 0;
      while (!in_ready && w < 200) begin
        @(posedge clk); #1;
        w++;
      end
      if (!in_ready) begin
        checks++; failures++;
        $display("[TB] FAIL send_timeout: beat %0d in_ready=%b required 1", k, in_ready);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (push) begin
      e.blk = model(t0, n);
      e.typ = t0;
      sb.push_back(e);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_coef = '0;
    scan_type = 2'd0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL rst_in_ready: got %b required 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_out_valid: got %b required 0", out_valid); end
    checks++; if (out_block !== '0) begin failures++; $display("[TB] FAIL rst_out_block: got %h required 0", out_block); end
    checks++; if (out_scan_type !== 2'd0) begin failures++; $display("[TB] FAIL rst_scan_type: got %0d required 0", out_scan_type); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL post_rst_ready: got %b required 1", in_ready); end
  endtask

  task automatic test_ver();
    exp_t e;
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) cv[k] = W'(k + 1);
    send_block(2'd2, 2'd2, 15, -1, 0, 1'b0);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL ver_early_valid: got %b required 0", out_valid); end
    send_block(2'd2, 2'd2, 16, -1, 15, 1'b1);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL ver_latency: out_valid got %b required 1", out_valid); end
    checks++; if (elem(0) !== W'(1)) begin failures++; $display("[TB] FAIL ver_r0: got %0d required 1", elem(0)); end
    checks++; if (elem(4) !== W'(2)) begin failures++; $display("[TB] FAIL ver_r4: got %0d required 2", elem(4)); end
    checks++; if (elem(1) !== W'(5)) begin failures++; $display("[TB] FAIL ver_r1: got %0d required 5", elem(1)); end
    checks++; if (elem(15) !== W'(16)) begin failures++; $display("[TB] FAIL ver_r15: got %0d required 16", elem(15)); end
    checks++; if (out_scan_type !== 2'd2) begin failures++; $display("[TB] FAIL ver_type: got %0d required 2", out_scan_type); end
    checks++;
    if (sb.size() == 0) begin failures++; $display("[TB] FAIL ver_block: got %h required queued block (queue empty)", out_block); end
    else begin e = sb.pop_front(); if (out_block !== e.blk) begin failures++; $display("[TB] FAIL ver_block: got %h required %h", out_block, e.blk); end end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL ver_drained: out_valid got %b required 0", out_valid); end
  endtask

  task automatic test_diag();
    exp_t e;
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) cv[k] = W'(100 + k);
    send_block(2'd0, 2'd0, 16, -1, 0, 1'b1);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL diag_valid: got %b required 1", out_valid); end
    checks++; if (elem(2) !== W'(104)) begin failures++; $display("[TB] FAIL diag_r2: got %0d required 104", elem(2)); end
    checks++; if (elem(4) !== W'(102)) begin failures++; $display("[TB] FAIL diag_r4: got %0d required 102", elem(4)); end
    checks++; if (elem(10) !== W'(112)) begin failures++; $display("[TB] FAIL diag_r10: got %0d required 112", elem(10)); end
    checks++; if (elem(12) !== W'(110)) begin failures++; $display("[TB] FAIL diag_r12: got %0d required 110", elem(12)); end
    checks++; if (elem(15) !== W'(115)) begin failures++; $display("[TB] FAIL diag_r15: got %0d required 115", elem(15)); end
    checks++;
    if (sb.size() == 0) begin failures++; $display("[TB] FAIL diag_block: got %h required queued block (queue empty)", out_block); end
    else begin e = sb.pop_front(); if (out_block !== e.blk) begin failures++; $display("[TB] FAIL diag_block: got %h required %h", out_block, e.blk); end end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int a0;
    out_ready = 1'b0;
    a0 = acc_cnt;
    for (int k = 0; k < 16; k++) cv[k] = W'(200 + k);
    send_block(2'd1, 2'd1, 16, -1, 0, 1'b1);
    for (int k = 0; k < 16; k++) cv[k] = W'(300 + k);
    send_block(2'd1, 2'd1, 16, -1, 0, 1'b1);
    // First beat of a third block is presented and must be held off.
    for (int k = 0; k < 16; k++) cv[k] = W'(400 + k);
    in_valid = 1'b1; in_coef = cv[0]; scan_type = 2'd1; in_last = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL stall_ready: cycle %0d got %b required 0", i, in_ready); end
      checks++; if (sb.size() > 0 && out_block !== sb[0].blk) begin failures++; $display("[TB] FAIL stall_stable: cycle %0d got %h required %h", i, out_block, sb[0].blk); end
      @(posedge clk); #1;
    end
    checks++; if (acc_cnt - a0 !== 32) begin failures++; $display("[TB] FAIL stall_accepted: got %0d required 32", acc_cnt - a0); end
    checks++;
    if (sb.size() == 0) begin failures++; $display("[TB] FAIL b2b_first: got %h required queued block (queue empty)", out_block); end
    else begin e = sb.pop_front(); if (out_block !== e.blk || out_valid !== 1'b1) begin failures++; $display("[TB] FAIL b2b_first: got %h valid %b required %h valid 1", out_block, out_valid, e.blk); end end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL b2b_ready_return: got %b required 1", in_ready); end
    checks++;
    if (sb.size() == 0) begin failures++; $display("[TB] FAIL b2b_second: got %h required queued block (queue empty)", out_block); end
    else begin e = sb.pop_front(); if (out_block !== e.blk || out_valid !== 1'b1) begin failures++; $display("[TB] FAIL b2b_second: got %h valid %b required %h valid 1", out_block, out_valid, e.blk); end end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL b2b_empty: out_valid got %b required 0", out_valid); end
    send_block(2'd1, 2'd1, 16, -1, 1, 1'b1);
    checks++;
    if (sb.size() == 0) begin failures++; $display("[TB] FAIL b2b_held_beat: got %h required queued block (queue empty)", out_block); end
    else begin e = sb.pop_front(); if (out_block !== e.blk || out_valid !== 1'b1) begin failures++; $display("[TB] FAIL b2b_held_beat: got %h valid %b required %h valid 1", out_block, out_valid, e.blk); end end
    @(posedge clk); #1;
  endtask

  task automatic test_last();
    exp_t e;
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) cv[k] = W'(11 + k);
    cv[0] = W'(7); cv[1] = W'(-3); cv[2] = W'(9);
`ifdef LAST_ZERO_FILL_EN
    send_block(2'd1, 2'd1, 3, 2, 0, 1'b1);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL last_valid: got %b required 1", out_valid); end
    checks++; if (elem(1) !== W'(-3)) begin failures++; $display("[TB] FAIL last_r1: got %0d required -3", $signed(elem(1))); end
    checks++; if (elem(3) !== W'(0)) begin failures++; $display("[TB] FAIL last_r3: got %0d required 0", elem(3)); end
`else
    send_block(2'd1, 2'd1, 3, 2, 0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL last_ignored: cycle %0d out_valid got %b required 0", i, out_valid); end
      @(posedge clk); #1;
    end
    send_block(2'd1, 2'd1, 16, -1, 3, 1'b1);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL last_full_valid: got %b required 1", out_valid); end
`endif
    checks++;
    if (sb.size() == 0) begin failures++; $display("[TB] FAIL last_block: got %h required queued block (queue empty)", out_block); end
    else begin e = sb.pop_front(); if (out_block !== e.blk) begin failures++; $display("[TB] FAIL last_block: got %h required %h", out_block, e.blk); end end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    exp_t e;
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) cv[k] = W'(500 + k);
    send_block(2'd0, 2'd0, 7, -1, 0, 1'b0);
    in_valid = 1'b1; in_coef = cv[7]; rst_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL midrst_ready: got %b required 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL midrst_valid: got %b required 0", out_valid); end
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 16; k++) cv[k] = W'(k * 3 - 20);
    send_block(2'd2, 2'd2, 16, -1, 0, 1'b1);
    checks++; if (out_valid !== 1'b1 || out_scan_type !== 2'd2) begin failures++; $display("[TB] FAIL midrst_out: valid %b type %0d required valid 1 type 2", out_valid, out_scan_type); end
    checks++;
    if (sb.size() == 0) begin failures++; $display("[TB] FAIL midrst_block: got %h required queued block (queue empty)", out_block); end
    else begin e = sb.pop_front(); if (out_block !== e.blk) begin failures++; $display("[TB] FAIL midrst_block: got %h required %h", out_block, e.blk); end end
    @(posedge clk); #1;
  endtask

  task automatic test_type3();
    exp_t e;
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) cv[k] = W'(k * 7 - 50);
    send_block(2'd3, 2'd1, 16, -1, 0, 1'b1);
    checks++; if (out_valid !== 1'b1 || out_scan_type !== 2'd3) begin failures++; $display("[TB] FAIL type3_out: valid %b type %0d required valid 1 type 3", out_valid, out_scan_type); end
    checks++;
    if (sb.size() == 0) begin failures++; $display("[TB] FAIL type3_block: got %h required queued block (queue empty)", out_block); end
    else begin e = sb.pop_front(); if (out_block !== e.blk) begin failures++; $display("[TB] FAIL type3_block: got %h required %h", out_block, e.blk); end end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_ver();
    test_diag();
    test_back_to_back();
    test_last();
    test_reset_mid();
    test_type3();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inv_scan_4x4.md
Name: inv_scan_4x4

Overview:
- Inverse-scan (de-scan) buffer for 4x4 transform blocks on the RDOQ/entropy path.
- Accepts 16 coefficients streamed in scan order (diagonal, horizontal or vertical) and places each at its raster position.
- Presents each completed block as one parallel raster-order word.
- Ping-pong buffered: one block fills while the previous block waits for the consumer.

Parameters:
- COEF_W, 16, signed coefficient width in bits.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- scan_type  in  2  0=diag, 1=hor, 2=ver, 3=treated as diag; sampled on the first beat of each block
- in_valid  in  1  input coefficient valid
- in_ready  out  1  input can accept a beat
- in_coef  in  COEF_W  coefficient at the current scan position
- in_last  in  1  last significant coefficient marker (used only with the optional feature)
- out_valid  out  1  completed block available
- out_ready  in  1  consumer accepts the block
- out_block  out  16*COEF_W  raster-order block; element r occupies bits [r*COEF_W +: COEF_W], r = row*4 + col
- out_scan_type  out  2  scan type the presented block was written with

Behaviour:
- Scan-to-raster map, indexed by scan position k = 0..15:
  - diag: 0,1,4,5,2,3,6,7,8,9,12,13,10,11,14,15
  - hor: identity
  - ver: 0,4,8,12,1,5,9,13,2,6,10,14,3,7,11,15
  - Must match the team's forward scan ROM exactly.
- State:
  - Two banks of 16 x COEF_W, each with a full flag, a 16-bit written mask and a latched scan type.
  - wr_sel and rd_sel bank pointers.
  - 4-bit scan counter cnt.
- Accept rule: a beat is accepted when in_valid && in_ready. in_ready = !full[wr_sel], and is forced to 0 while rst_n is low.
- When cnt == 0, the accepted beat latches scan_type into the bank. Changes to scan_type mid-block are ignored.
- Each accepted beat:
  - writes bank[wr_sel][map(type,cnt)] = in_coef;
  - sets the matching mask bit;
  - increments cnt.
- Block completes on the accept at cnt == 15:
  - full[wr_sel] <= 1;
  - wr_sel toggles;
  - cnt <= 0.
- Output side:
  - out_valid = full[rd_sel], registered.
  - out_block = bank[rd_sel] with unwritten positions (mask bit 0) forced to zero.
  - out_scan_type = bank[rd_sel] latched type.
- Output handshake: on out_valid && out_ready, full[rd_sel] <= 0, the mask clears and rd_sel toggles. out_block must stay stable while out_valid && !out_ready.
- Latency: out_valid rises the cycle after the completing beat.
- Throughput: 1 coefficient/cycle sustained, with no bubble between blocks when out_ready is held at 1.
- Simultaneous events: completing a fill of one bank in the same cycle as draining the other is legal and both take effect.
- Both banks full: in_ready = 0 until a drain. The beat presented while stalled is held by the producer and not lost.
- cnt wraps 15 -> 0 only on block completion.
- Reset values:
  - cnt, wr_sel, rd_sel, full flags and masks all 0.
  - out_valid = 0, out_block = 0, out_scan_type = 0.
  - A partial block in progress at reset is discarded.

Optional Feature:
- Macro: LAST_ZERO_FILL_EN.
- Defined: an accepted beat with in_last = 1 completes the block immediately at any cnt, with the same actions as the cnt == 15 completion. Raster positions not written read as 0 through the mask. in_last at cnt == 15 behaves as normal completion.
- Undefined: in_last is ignored and every block is exactly 16 beats. The mask logic may be removed, but out_block must still be 0 after reset.

Test Plan:
- ver scan, in_coef = k+1 for k = 0..15, out_ready = 1 -> out_valid exactly one cycle after the 16th beat; out_block raster[0]=1, raster[4]=2, raster[1]=5, raster[15]=16; out_scan_type = 2.
- diag scan, in_coef = 100+k -> raster[2]=104, raster[4]=102, raster[10]=112, raster[12]=110, raster[15]=115.
- out_ready = 0, in_valid held high, hor scan -> exactly 32 beats accepted, then in_ready = 0. Raise out_ready -> block 1 then block 2 delivered in order with stable data while stalled; in_ready returns the cycle after the first drain.
- LAST_ZERO_FILL_EN defined, hor scan, values 7, -3, 9 with in_last on the 3rd beat -> raster[0..2] = 7, -3, 9, all other positions 0, out_valid the next cycle. Without the macro, the same stimulus produces no out_valid until 16 beats.
- Reset asserted after 7 beats -> out_valid = 0 and in_ready = 0 during reset. The next 16-beat ver block is output correctly with no leftover values from the discarded partial block.
- scan_type = 3 on the first beat, switched to 1 mid-block -> block mapped as diag; out_scan_type = 3.
